rvh_l1d_spram_port_ctrl: RTL and testbench

- Front-end controller that sits directly upstream of the L1D single-port SRAM wrapper (generic_spram) and drives its ce/we/biten/addr/din pins.
- Merges a read-request channel and a write-request channel onto the one RAM port, issuing at most one RAM operation per cycle.
- Buffers writes in a small in-order write queue and stalls reads that hit a pending write address.
- Returns read data with the requester's tag exactly RAM_LATENCY cycles after issue.

---
 rtl/rvh_l1d_spram_port_ctrl_pkg.sv | 22 ++
 rtl/rvh_l1d_spram_port_ctrl_if.sv | 33 +++
 rtl/rvh_l1d_spram_wq.sv | 87 ++++++++
 rtl/rvh_l1d_spram_port_ctrl.sv | 113 +++++++++++
 tb/tb_rvh_l1d_spram_port_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvh_l1d_spram_port_ctrl_pkg.sv
// Shared types and elaboration-time parameter checks for the L1D single-port RAM front end.
`ifndef RVH_L1D_SPRAM_PKG_SV
`define RVH_L1D_SPRAM_PKG_SV

`define RVH_L1D_STATIC_CHECK(lbl, cond) \
    if (!(cond)) begin : lbl \
        $error("rvh_l1d_spram parameter check failed"); \
    end

package rvh_l1d_spram_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } ram_op_e;

    localparam int unsigned MAX_RAM_LATENCY = 4;

endpackage

`endif

// File: rtl/rvh_l1d_spram_port_ctrl_if.sv
// Requester-side read/write request and read response channels of the L1D RAM port controller.
// master = requester, slave = controller; rd/wr requests are valid/ready, responses have no backpressure.
interface rvh_l1d_spram_port_ctrl_if #(
    parameter int W     = 64,
    parameter int P     = 8,
    parameter int LOG2D = 6,
    parameter int ID_W  = 4
) ();
    logic             rd_req_vld;
    logic             rd_req_rdy;
    logic [LOG2D-1:0] rd_req_addr;
    logic [ID_W-1:0]  rd_req_id;
    logic             rd_resp_vld;
    logic [ID_W-1:0]  rd_resp_id;
    logic [W-1:0]     rd_resp_data;
    logic             wr_req_vld;
    logic             wr_req_rdy;
    logic [LOG2D-1:0] wr_req_addr;
    logic [W-1:0]     wr_req_data;
    logic [W/P-1:0]   wr_req_mask;

    modport master (
        output rd_req_vld, rd_req_addr, rd_req_id,
        output wr_req_vld, wr_req_addr, wr_req_data, wr_req_mask,
        input  rd_req_rdy, rd_resp_vld, rd_resp_id, rd_resp_data, wr_req_rdy
    );

    modport slave (
        input  rd_req_vld, rd_req_addr, rd_req_id,
        input  wr_req_vld, wr_req_addr, wr_req_data, wr_req_mask,
        output rd_req_rdy, rd_resp_vld, rd_resp_id, rd_resp_data, wr_req_rdy
    );
endinterface

// File: rtl/rvh_l1d_spram_wq.sv
// In-order write queue with per-entry valid bits and a combinational address-hit query.
// Head is visible combinationally; enqueue is refused while full, dequeue ignored while empty.
module rvh_l1d_spram_wq #(
    parameter int W     = 64,
    parameter int P     = 8,
    parameter int LOG2D = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_vld_i,
    input  logic [LOG2D-1:0] enq_addr_i,
    input  logic [W-1:0]     enq_data_i,
    input  logic [W/P-1:0]   enq_mask_i,
    input  logic             deq_i,
    input  logic [LOG2D-1:0] query_addr_i,
    output logic             hit_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LOG2D-1:0] head_addr_o,
    output logic [W-1:0]     head_data_o,
    output logic [W/P-1:0]   head_mask_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LOG2D-1:0] addr_q [DEPTH];
    logic [W-1:0]     data_q [DEPTH];
    logic [W/P-1:0]   mask_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             enq, deq;

    assign full_o      = (cnt_q == CW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign enq         = enq_vld_i && !full_o;
    assign deq         = deq_i && !empty_o;
    assign head_addr_o = addr_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign head_mask_o = mask_q[rptr_q];

    always_comb begin
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (deq) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 1'b1;
        end
        if (enq) begin
            vld_d[wptr_q] = 1'b1;
            wptr_d        = wptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end

    // Hazard check sees only entries present at the start of the cycle.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == query_addr_i)) hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wptr_q] <= enq_addr_i;
            data_q[wptr_q] <= enq_data_i;
            mask_q[wptr_q] <= enq_mask_i;
        end
    end
endmodule

// File: rtl/rvh_l1d_spram_port_ctrl.sv
// Merges read and write requests onto one SRAM port; read data returns RAM_LATENCY cycles after issue.
// Writes wait in a queue; reads stall while full or while hitting a queued write address.
module rvh_l1d_spram_port_ctrl
    import rvh_l1d_spram_pkg::*;
#(
    parameter int W           = 64,
    parameter int P           = 8,
    parameter int LOG2D       = 6,
    parameter int RAM_LATENCY = 1,
    parameter int WQ_DEPTH    = 4,
    parameter int ID_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rvh_l1d_spram_port_ctrl_if.slave req_if,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [W/P-1:0]         ram_biten_o,
    output logic [LOG2D-1:0]       ram_addr_o,
    output logic [W-1:0]           ram_din_o,
    input  logic [W-1:0]           ram_dout_i,
    output logic                   wq_empty_o
);
    `RVH_L1D_STATIC_CHECK(g_chk_lanes, (W % P) == 0)
    `RVH_L1D_STATIC_CHECK(g_chk_lat, (RAM_LATENCY >= 1) && (RAM_LATENCY <= int'(MAX_RAM_LATENCY)))
    `RVH_L1D_STATIC_CHECK(g_chk_wq, (WQ_DEPTH >= 2) && ((WQ_DEPTH & (WQ_DEPTH - 1)) == 0))

    logic             wq_full, wq_empty, rd_hit;
    logic [LOG2D-1:0] head_addr;
    logic [W-1:0]     head_data;
    logic [W/P-1:0]   head_mask;
    ram_op_e          op;

    logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]        pipe_id_q [RAM_LATENCY];
    logic [ID_W-1:0]        pipe_id_d [RAM_LATENCY];

    rvh_l1d_spram_wq #(
        .W(W), .P(P), .LOG2D(LOG2D), .DEPTH(WQ_DEPTH)
    ) u_wq (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_vld_i   (req_if.wr_req_vld),
        .enq_addr_i  (req_if.wr_req_addr),
        .enq_data_i  (req_if.wr_req_data),
        .enq_mask_i  (req_if.wr_req_mask),
        .deq_i       (op == OP_WR),
        .query_addr_i(req_if.rd_req_addr),
        .hit_o       (rd_hit),
        .full_o      (wq_full),
        .empty_o     (wq_empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .head_mask_o (head_mask)
    );

    assign req_if.rd_req_rdy = !wq_full && !rd_hit;
    assign req_if.wr_req_rdy = !wq_full;
    assign wq_empty_o        = wq_empty;

    // A full queue forces a drain so reads cannot starve writes indefinitely.
    always_comb begin
        op = OP_IDLE;
        if (wq_full)                                op = OP_WR;
        else if (req_if.rd_req_vld && !rd_hit)      op = OP_RD;
        else if (!wq_empty)                         op = OP_WR;
    end

    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_biten_o = '0;
        ram_addr_o  = '0;
        ram_din_o   = '0;
        case (op)
            OP_RD: begin
                ram_ce_o   = 1'b1;
                ram_addr_o = req_if.rd_req_addr;
            end
            OP_WR: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_biten_o = head_mask;
                ram_addr_o  = head_addr;
                ram_din_o   = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        pipe_vld_d[0] = (op == OP_RD);
        pipe_id_d[0]  = (op == OP_RD) ? req_if.rd_req_id : '0;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) pipe_id_q[i] <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < RAM_LATENCY; i++) pipe_id_q[i] <= pipe_id_d[i];
        end
    end

    assign req_if.rd_resp_vld  = pipe_vld_q[RAM_LATENCY-1];
    assign req_if.rd_resp_id   = pipe_id_q[RAM_LATENCY-1];
    assign req_if.rd_resp_data = pipe_vld_q[RAM_LATENCY-1] ? ram_dout_i : '0;
endmodule

// File: tb/tb_rvh_l1d_spram_port_ctrl.sv
// Bench for the L1D RAM port controller: two instances (latency 1 and 3) with behavioural SRAMs.
module tb_rvh_l1d_spram_port_ctrl;
    localparam int W = 16, P = 8, LOG2D = 6, ID_W = 4, WQ = 4;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [W-1:0]    data;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb1[$];
    exp_t sb3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rvh_l1d_spram_port_ctrl_if #(.W(W), .P(P), .LOG2D(LOG2D), .ID_W(ID_W)) if1 ();
    rvh_l1d_spram_port_ctrl_if #(.W(W), .P(P), .LOG2D(LOG2D), .ID_W(ID_W)) if3 ();

    logic             ce1, we1, wqe1, ce3, we3, wqe3;
    logic [1:0]       be1, be3;
    logic [LOG2D-1:0] ad1, ad3;
    logic [W-1:0]     di1, do1, di3, do3;

    rvh_l1d_spram_port_ctrl #(.W(W), .P(P), .LOG2D(LOG2D), .RAM_LATENCY(1), .WQ_DEPTH(WQ), .ID_W(ID_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_if(if1), .ram_ce_o(ce1), .ram_we_o(we1), .ram_biten_o(be1),
        .ram_addr_o(ad1), .ram_din_o(di1), .ram_dout_i(do1), .wq_empty_o(wqe1));

    rvh_l1d_spram_port_ctrl #(.W(W), .P(P), .LOG2D(LOG2D), .RAM_LATENCY(3), .WQ_DEPTH(WQ), .ID_W(ID_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_if(if3), .ram_ce_o(ce3), .ram_we_o(we3), .ram_biten_o(be3),
        .ram_addr_o(ad3), .ram_din_o(di3), .ram_dout_i(do3), .wq_empty_o(wqe3));

    function automatic logic [W-1:0] init_val(input int a);
        return (a == 5) ? 16'h00A5 : 16'(16'hC000 + a);
    endfunction

    // Behavioural SRAMs, contents reloaded while reset is held.
    logic [W-1:0] mem1 [64];
    logic [W-1:0] mem3 [64];
    logic [W-1:0] rp1;
    logic [W-1:0] rp3 [3];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 64; a++) mem1[a] <= init_val(a);
        end else if (ce1 && we1) begin
            for (int l = 0; l < 2; l++) if (be1[l]) mem1[ad1][l*8 +: 8] <= di1[l*8 +: 8];
        end
        rp1 <= (ce1 && !we1) ? mem1[ad1] : '0;
    end
    assign do1 = rp1;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 64; a++) mem3[a] <= init_val(a);
        end else if (ce3 && we3) begin
            for (int l = 0; l < 2; l++) if (be3[l]) mem3[ad3][l*8 +: 8] <= di3[l*8 +: 8];
        end
        rp3[0] <= (ce3 && !we3) ? mem3[ad3] : '0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign do3 = rp3[2];

    always @(negedge clk) begin : mon1
        exp_t e;
        if (if1.rd_resp_vld !== 1'b0) begin
            total++;
            if (sb1.size() == 0) begin
                bad++;
                $display("FAIL resp1_unexpected: got vld=%b id=%0d data=%h at cyc %0d, required no response",
                         if1.rd_resp_vld, if1.rd_resp_id, if1.rd_resp_data, cyc);
            end else begin
                e = sb1.pop_front();
                if (if1.rd_resp_id !== e.id || if1.rd_resp_data !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL resp1: got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d",
                             if1.rd_resp_id, if1.rd_resp_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (if3.rd_resp_vld !== 1'b0) begin
            total++;
            if (sb3.size() == 0) begin
                bad++;
                $display("FAIL resp3_unexpected: got vld=%b id=%0d data=%h at cyc %0d, required no response",
                         if3.rd_resp_vld, if3.rd_resp_id, if3.rd_resp_data, cyc);
            end else begin
                e = sb3.pop_front();
                if (if3.rd_resp_id !== e.id || if3.rd_resp_data !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL resp3: got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d",
                             if3.rd_resp_id, if3.rd_resp_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic idle_all();
        if1.rd_req_vld = 1'b0; if1.rd_req_addr = '0; if1.rd_req_id = '0;
        if1.wr_req_vld = 1'b0; if1.wr_req_addr = '0; if1.wr_req_data = '0; if1.wr_req_mask = '0;
        if3.rd_req_vld = 1'b0; if3.rd_req_addr = '0; if3.rd_req_id = '0;
        if3.wr_req_vld = 1'b0; if3.wr_req_addr = '0; if3.wr_req_data = '0; if3.wr_req_mask = '0;
    endtask

    // Holds a read on instance 1 until accepted (bounded), then records the expected response.
    task automatic rd1(input logic [LOG2D-1:0] a, input logic [ID_W-1:0] id, input logic [W-1:0] exp_d);
        int n = 0;
        @(negedge clk);
        if1.rd_req_vld = 1'b1; if1.rd_req_addr = a; if1.rd_req_id = id;
        #1;
        while (if1.rd_req_rdy !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (if1.rd_req_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rd1_accept: addr=%0d rdy=%b after %0d cycles, required 1", a, if1.rd_req_rdy, n);
        end else begin
            sb1.push_back('{id, exp_d, cyc + 1});
        end
        @(negedge clk);
        if1.rd_req_vld = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (if1.rd_resp_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b required 0", if1.rd_resp_vld); end
        total++; if (if1.rd_resp_id !== '0) begin bad++; $display("FAIL reset_id: got %0d required 0", if1.rd_resp_id); end
        total++; if (if1.rd_resp_data !== '0) begin bad++; $display("FAIL reset_data: got %h required 0", if1.rd_resp_data); end
        total++; if (wqe1 !== 1'b1) begin bad++; $display("FAIL reset_wq_empty: got %b required 1", wqe1); end
        total++; if (if1.wr_req_rdy !== 1'b1) begin bad++; $display("FAIL reset_wr_rdy: got %b required 1", if1.wr_req_rdy); end
        total++; if (ce1 !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b required 0", ce1); end
        total++; if (if3.rd_resp_vld !== 1'b0 || wqe3 !== 1'b1) begin
            bad++; $display("FAIL reset_inst3: got vld=%b empty=%b required 0/1", if3.rd_resp_vld, wqe3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        @(negedge clk);
        if1.rd_req_vld = 1'b1; if1.rd_req_addr = 6'd5; if1.rd_req_id = 4'd3;
        #1;
        total++;
        if (if1.rd_req_rdy !== 1'b1 || ce1 !== 1'b1 || we1 !== 1'b0 || ad1 !== 6'd5) begin
            bad++;
            $display("FAIL single_issue: got rdy=%b ce=%b we=%b addr=%0d required 1/1/0/5", if1.rd_req_rdy, ce1, we1, ad1);
        end
        sb1.push_back('{4'd3, 16'h00A5, cyc + 1});
        @(negedge clk);
        if1.rd_req_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_raw();
        @(negedge clk);
        if1.wr_req_vld = 1'b1; if1.wr_req_addr = 6'd7; if1.wr_req_data = 16'h1122; if1.wr_req_mask = 2'b01;
        #1;
        total++;
        if (if1.wr_req_rdy !== 1'b1 || ce1 !== 1'b0) begin
            bad++; $display("FAIL raw_enq: got wr_rdy=%b ce=%b required 1/0", if1.wr_req_rdy, ce1);
        end
        @(negedge clk);
        if1.wr_req_vld = 1'b0;
        if1.rd_req_vld = 1'b1; if1.rd_req_addr = 6'd7; if1.rd_req_id = 4'd9;
        #1;
        total++;
        if (if1.rd_req_rdy !== 1'b0 || we1 !== 1'b1 || be1 !== 2'b01 || ad1 !== 6'd7 || di1 !== 16'h1122 || wqe1 !== 1'b0) begin
            bad++;
            $display("FAIL raw_stall: got rdy=%b we=%b be=%b addr=%0d din=%h empty=%b required 0/1/01/7/1122/0",
                     if1.rd_req_rdy, we1, be1, ad1, di1, wqe1);
        end
        @(negedge clk);
        #1;
        total++;
        if (if1.rd_req_rdy !== 1'b1 || ce1 !== 1'b1 || we1 !== 1'b0 || wqe1 !== 1'b1) begin
            bad++;
            $display("FAIL raw_release: got rdy=%b ce=%b we=%b empty=%b required 1/1/0/1", if1.rd_req_rdy, ce1, we1, wqe1);
        end
        sb1.push_back('{4'd9, 16'hC022, cyc + 1});
        @(negedge clk);
        if1.rd_req_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if1.rd_req_vld = 1'b1; if1.rd_req_addr = 6'(20 + k); if1.rd_req_id = 4'(k);
            if1.wr_req_vld = 1'b1; if1.wr_req_addr = 6'(10 + k); if1.wr_req_data = 16'(16'h3000 + 10 + k);
            if1.wr_req_mask = 2'b11;
            #1;
            total++;
            if (if1.rd_req_rdy !== 1'b1 || if1.wr_req_rdy !== 1'b1 || ce1 !== 1'b1 || we1 !== 1'b0) begin
                bad++;
                $display("FAIL fill_%0d: got rd_rdy=%b wr_rdy=%b ce=%b we=%b required 1/1/1/0",
                         k, if1.rd_req_rdy, if1.wr_req_rdy, ce1, we1);
            end
            sb1.push_back('{4'(k), init_val(20 + k), cyc + 1});
        end
        @(negedge clk);
        if1.rd_req_addr = 6'd24; if1.rd_req_id = 4'd4;
        if1.wr_req_addr = 6'd14; if1.wr_req_data = 16'h300E;
        #1;
        total++;
        if (if1.wr_req_rdy !== 1'b0 || if1.rd_req_rdy !== 1'b0 || we1 !== 1'b1 || ad1 !== 6'd10 || di1 !== 16'h300A) begin
            bad++;
            $display("FAIL full_drain: got wr_rdy=%b rd_rdy=%b we=%b addr=%0d din=%h required 0/0/1/10/300a",
                     if1.wr_req_rdy, if1.rd_req_rdy, we1, ad1, di1);
        end
        @(negedge clk);
        #1;
        total++;
        if (if1.rd_req_rdy !== 1'b1 || if1.wr_req_rdy !== 1'b1 || we1 !== 1'b0 || ad1 !== 6'd24) begin
            bad++;
            $display("FAIL full_recover: got rd_rdy=%b wr_rdy=%b we=%b addr=%0d required 1/1/0/24",
                     if1.rd_req_rdy, if1.wr_req_rdy, we1, ad1);
        end
        sb1.push_back('{4'd4, init_val(24), cyc + 1});
        @(negedge clk);
        if1.rd_req_vld = 1'b0; if1.wr_req_vld = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (wqe1 !== 1'b1) begin bad++; $display("FAIL full_drained: got empty=%b required 1", wqe1); end
        for (int a = 10; a <= 14; a++) rd1(6'(a), 4'(a), 16'(16'h3000 + a));
        repeat (2) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        if1.rd_req_vld = 1'b1; if1.rd_req_addr = 6'd1; if1.rd_req_id = 4'd5;
        if1.wr_req_vld = 1'b1; if1.wr_req_addr = 6'd1; if1.wr_req_data = 16'h2222; if1.wr_req_mask = 2'b11;
        #1;
        total++;
        if (if1.rd_req_rdy !== 1'b1 || if1.wr_req_rdy !== 1'b1 || ce1 !== 1'b1 || we1 !== 1'b0 || ad1 !== 6'd1) begin
            bad++;
            $display("FAIL same_rd_first: got rd_rdy=%b wr_rdy=%b ce=%b we=%b addr=%0d required 1/1/1/0/1",
                     if1.rd_req_rdy, if1.wr_req_rdy, ce1, we1, ad1);
        end
        sb1.push_back('{4'd5, 16'hC001, cyc + 1});
        @(negedge clk);
        if1.rd_req_vld = 1'b0; if1.wr_req_vld = 1'b0;
        #1;
        total++;
        if (ce1 !== 1'b1 || we1 !== 1'b1 || ad1 !== 6'd1 || di1 !== 16'h2222 || be1 !== 2'b11) begin
            bad++;
            $display("FAIL same_wr_next: got ce=%b we=%b addr=%0d din=%h be=%b required 1/1/1/2222/11",
                     ce1, we1, ad1, di1, be1);
        end
        rd1(6'd1, 4'd6, 16'h2222);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency3();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if3.rd_req_vld = 1'b1; if3.rd_req_addr = 6'(i); if3.rd_req_id = 4'(i);
            #1;
            total++;
            if (if3.rd_req_rdy !== 1'b1 || ce3 !== 1'b1 || we3 !== 1'b0) begin
                bad++;
                $display("FAIL lat3_issue_%0d: got rdy=%b ce=%b we=%b required 1/1/0", i, if3.rd_req_rdy, ce3, we3);
            end
            sb3.push_back('{4'(i), init_val(i), cyc + 3});
        end
        @(negedge clk);
        if3.rd_req_vld = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        if3.wr_req_vld = 1'b1; if3.wr_req_addr = 6'd40; if3.wr_req_data = 16'h4444; if3.wr_req_mask = 2'b11;
        @(negedge clk);
        if3.wr_req_addr = 6'd41;
        if3.rd_req_vld = 1'b1; if3.rd_req_addr = 6'd30; if3.rd_req_id = 4'd1;
        @(negedge clk);
        if3.wr_req_addr = 6'd42;
        if3.rd_req_addr = 6'd31; if3.rd_req_id = 4'd2;
        @(negedge clk);
        #1;
        total++;
        if (wqe3 !== 1'b0) begin bad++; $display("FAIL inflight_queued: got empty=%b required 0", wqe3); end
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (ce3 !== 1'b0 || wqe3 !== 1'b1 || if3.rd_resp_vld !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_%0d: got ce=%b empty=%b vld=%b required 0/1/0", i, ce3, wqe3, if3.rd_resp_vld);
            end
        end
        @(negedge clk);
        if3.rd_req_vld = 1'b1; if3.rd_req_addr = 6'd2; if3.rd_req_id = 4'd7;
        #1;
        total++;
        if (if3.rd_req_rdy !== 1'b1 || ce3 !== 1'b1) begin
            bad++; $display("FAIL post_reset_read: got rdy=%b ce=%b required 1/1", if3.rd_req_rdy, ce3);
        end
        sb3.push_back('{4'd7, init_val(2), cyc + 3});
        @(negedge clk);
        if3.rd_req_vld = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_raw();
        test_full();
        test_same_cycle();
        test_latency3();
        test_reset_inflight();
        repeat (3) @(negedge clk);
        total++;
        if (sb1.size() != 0) begin bad++; $display("FAIL sb1_leftover: got %0d pending responses required 0", sb1.size()); end
        total++;
        if (sb3.size() != 0) begin bad++; $display("FAIL sb3_leftover: got %0d pending responses required 0", sb3.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
